// File: rtl/filter_peak_detector_pkg.sv
// Shared types for the peak detector: sample width, FSM state and the event payload.
// Event fields are sized for the widest supported timestamp/width configuration.
package filter_peak_detector_pkg;

  localparam int unsigned SIZE_FILTER_DATA = 16;
  localparam int unsigned EVT_TS_WIDTH     = 64;
  localparam int unsigned EVT_W_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    WAIT_LOW,
    DEAD
  } state_e;

  typedef struct packed {
    logic signed [SIZE_FILTER_DATA-1:0] amp;
    logic [EVT_TS_WIDTH-1:0]            tstamp;
    logic [EVT_W_WIDTH-1:0]             width;
    logic                               pileup;
  } event_t;

endpackage

// File: rtl/peak_event_buffer.sv
// One-entry event holding register with valid/ready handoff, load-or-drop decision
// and a saturating count of events that arrived while the slot was still occupied.
module peak_event_buffer
  import filter_peak_detector_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  event_t     i_event,
  input  logic       i_ready,
  output logic       o_valid,
  output event_t     o_event,
  output logic [7:0] o_lost_count
);

  logic       r_valid;
  event_t     r_event;
  logic [7:0] r_lost;
  logic       w_accept;

  // The slot is free when empty or when its occupant is handed off this cycle.
  assign w_accept = !r_valid || i_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_event <= '0;
      r_lost  <= 8'd0;
    end else begin
      if (i_load && w_accept) begin
        r_valid <= 1'b1;
        r_event <= i_event;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_load && !w_accept && (r_lost != 8'hFF)) begin
        r_lost <= r_lost + 8'd1;
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_event      = r_event;
  assign o_lost_count = r_lost;

endmodule

// File: rtl/filter_peak_detector.sv
// Threshold-crossing pulse detector on the shaping-filter output: tracks peak, peak
// timestamp, width and pile-up per pulse, then hands one event to the readout buffer.
module filter_peak_detector
  import filter_peak_detector_pkg::*;
#(
  parameter int          THRESHOLD = 100,
  parameter int unsigned HOLDOFF   = 8,
  parameter int unsigned MAX_WIDTH = 64,
  parameter int unsigned TS_WIDTH  = 32,
  parameter int unsigned W_WIDTH   = 8
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] i_filter_data,
  output logic                               o_event_valid,
  input  logic                               i_event_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] o_event_amp,
  output logic        [TS_WIDTH-1:0]         o_event_time,
  output logic        [W_WIDTH-1:0]          o_event_width,
  output logic                               o_event_pileup,
  output logic        [7:0]                  o_lost_count,
  output logic                               o_busy
);

  localparam logic signed [SIZE_FILTER_DATA-1:0] LP_THRESHOLD = SIZE_FILTER_DATA'(THRESHOLD);
  localparam logic [W_WIDTH-1:0] LP_MAX_WIDTH = W_WIDTH'(MAX_WIDTH);
  localparam int unsigned LP_HO_W    = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam int unsigned LP_HO_LAST = (HOLDOFF == 0) ? 0 : HOLDOFF - 1;

  state_e                             r_state;
  logic        [TS_WIDTH-1:0]         r_ts;
  logic signed [SIZE_FILTER_DATA-1:0] r_max;
  logic        [TS_WIDTH-1:0]         r_t_max;
  logic        [W_WIDTH-1:0]          r_width;
  logic        [LP_HO_W-1:0]          r_dead;
  logic                               r_busy;

  logic                               w_above;
  logic                               w_new_peak;
  logic signed [SIZE_FILTER_DATA-1:0] w_new_max;
  logic        [TS_WIDTH-1:0]         w_new_t_max;
  logic        [W_WIDTH-1:0]          w_width_inc;
  logic                               w_load;
  event_t                             w_event;
  event_t                             w_buf_event;

  assign w_above     = i_filter_data > LP_THRESHOLD;
  assign w_new_peak  = w_above && (i_filter_data > r_max);
  assign w_new_max   = w_new_peak ? i_filter_data : r_max;
  assign w_new_t_max = w_new_peak ? r_ts : r_t_max;
  assign w_width_inc = r_width + W_WIDTH'(1);

  // Event completion: falling below threshold, or width hitting the pile-up limit.
  always_comb begin
    w_load         = 1'b0;
    w_event.amp    = r_max;
    w_event.tstamp = EVT_TS_WIDTH'(r_t_max);
    w_event.width  = EVT_W_WIDTH'(r_width);
    w_event.pileup = 1'b0;
    if (r_state == TRACK) begin
      if (w_above) begin
        w_event.amp    = w_new_max;
        w_event.tstamp = EVT_TS_WIDTH'(w_new_t_max);
        w_event.width  = EVT_W_WIDTH'(w_width_inc);
        w_event.pileup = 1'b1;
        w_load         = (w_width_inc == LP_MAX_WIDTH);
      end else begin
        w_load = 1'b1;
      end
    end else if ((r_state == IDLE) && w_above && (MAX_WIDTH <= 1)) begin
      w_event.amp    = i_filter_data;
      w_event.tstamp = EVT_TS_WIDTH'(r_ts);
      w_event.width  = EVT_W_WIDTH'(1);
      w_event.pileup = 1'b1;
      w_load         = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_ts    <= '0;
      r_max   <= '0;
      r_t_max <= '0;
      r_width <= '0;
      r_dead  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
      case (r_state)
        IDLE: begin
          if (w_above) begin
            r_max   <= i_filter_data;
            r_t_max <= r_ts;
            r_width <= W_WIDTH'(1);
            r_state <= (MAX_WIDTH <= 1) ? WAIT_LOW : TRACK;
            r_busy  <= 1'b1;
          end
        end
        TRACK: begin
          if (w_above) begin
            r_max   <= w_new_max;
            r_t_max <= w_new_t_max;
            r_width <= w_width_inc;
            if (w_width_inc == LP_MAX_WIDTH) begin
              r_state <= WAIT_LOW;
            end
          end else begin
            r_state <= DEAD;
            r_dead  <= '0;
          end
        end
        WAIT_LOW: begin
          if (!w_above) begin
            r_state <= DEAD;
            r_dead  <= '0;
          end
        end
        DEAD: begin
          if (r_dead == LP_HO_W'(LP_HO_LAST)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_dead <= r_dead + LP_HO_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  peak_event_buffer u_buffer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_load),
    .i_event      (w_event),
    .i_ready      (i_event_ready),
    .o_valid      (o_event_valid),
    .o_event      (w_buf_event),
    .o_lost_count (o_lost_count)
  );

  assign o_event_amp    = w_buf_event.amp;
  assign o_event_time   = TS_WIDTH'(w_buf_event.tstamp);
  assign o_event_width  = W_WIDTH'(w_buf_event.width);
  assign o_event_pileup = w_buf_event.pileup;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_filter_peak_detector.sv
// Bench for filter_peak_detector: directed scenarios plus random pulses, checked every
// cycle against a pulse-level reference model built from queues of the current pulse.
module tb_filter_peak_detector;

  localparam int TH    = 100;
  localparam int HOLD  = 4;
  localparam int MAXW  = 16;

  logic               clk = 1'b0;
  logic               i_reset;
  logic signed [15:0] i_filter_data;
  logic               i_event_ready;
  logic               o_event_valid;
  logic signed [15:0] o_event_amp;
  logic [31:0]        o_event_time;
  logic [7:0]         o_event_width;
  logic               o_event_pileup;
  logic [7:0]         o_lost_count;
  logic               o_busy;

  filter_peak_detector #(
    .THRESHOLD (TH),
    .HOLDOFF   (HOLD),
    .MAX_WIDTH (MAXW),
    .TS_WIDTH  (32),
    .W_WIDTH   (8)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_filter_data  (i_filter_data),
    .o_event_valid  (o_event_valid),
    .i_event_ready  (i_event_ready),
    .o_event_amp    (o_event_amp),
    .o_event_time   (o_event_time),
    .o_event_width  (o_event_width),
    .o_event_pileup (o_event_pileup),
    .o_lost_count   (o_lost_count),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model state: current pulse as queues, re-arm edge index, one output slot.
  longint             m_ts = 0;
  longint             m_rearm = 0;
  bit                 m_wait_low = 0;
  logic signed [15:0] q_amp[$];
  longint             q_tag[$];
  bit                 m_valid = 0;
  longint             m_amp = 0, m_time = 0, m_width = 0, m_pile = 0;
  int                 m_lost = 0;
  longint             last_tag = 0;

  function automatic longint dead_span();
    return (HOLD == 0) ? 2 : HOLD + 1;
  endfunction

  always @(posedge clk) begin
    logic signed [15:0] smp;
    bit rdy, done, pile;
    int best;
    longint e_amp, e_time, e_width;
    smp  = i_filter_data;
    rdy  = i_event_ready;
    done = 0;
    pile = 0;
    e_amp = 0; e_time = 0; e_width = 0;
    if (i_reset) begin
      m_ts = 0; m_rearm = 0; m_wait_low = 0;
      q_amp.delete(); q_tag.delete();
      m_valid = 0; m_amp = 0; m_time = 0; m_width = 0; m_pile = 0; m_lost = 0;
    end else begin
      if (m_wait_low) begin
        if (smp <= TH) begin
          m_wait_low = 0;
          m_rearm = m_ts + dead_span();
        end
      end else if (q_amp.size() > 0 || (m_ts >= m_rearm && smp > TH)) begin
        if (smp > TH) begin
          q_amp.push_back(smp);
          q_tag.push_back(m_ts);
          if (q_amp.size() == MAXW) begin
            done = 1; pile = 1; m_wait_low = 1;
          end
        end else begin
          done = 1;
          m_rearm = m_ts + dead_span();
        end
      end
      if (done) begin
        best = 0;
        for (int i = 1; i < q_amp.size(); i++) if (q_amp[i] > q_amp[best]) best = i;
        e_amp = q_amp[best];
        e_time = q_tag[best] & 64'hFFFF_FFFF;
        e_width = q_amp.size();
        q_amp.delete(); q_tag.delete();
        if (!m_valid || rdy) begin
          m_valid = 1; m_amp = e_amp; m_time = e_time; m_width = e_width; m_pile = pile;
        end else if (m_lost < 255) begin
          m_lost++;
        end
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      m_ts++;
    end
    #1;
    chk("valid", o_event_valid, m_valid);
    chk("busy", o_busy, (q_amp.size() > 0 || m_wait_low || m_ts < m_rearm) ? 1 : 0);
    chk("lost", o_lost_count, m_lost);
    chk("amp", o_event_amp, m_amp);
    chk("time", o_event_time, m_time);
    chk("width", o_event_width, m_width);
    chk("pileup", o_event_pileup, m_pile);
  end

  task automatic tick(input int v, input bit rdy);
    @(negedge clk);
    i_filter_data = 16'(v);
    i_event_ready = rdy;
    last_tag = m_ts;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    longint t_first, t_peak;
    int burst, v;
    i_reset = 1'b1;
    i_filter_data = '0;
    i_event_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_event_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_lost", o_lost_count, 0);
    i_reset = 1'b0;

    // Single pulse; 150 lands on ts 12.
    repeat (10) tick(0, 1);
    tick(50, 1); tick(150, 1); tick(300, 1); tick(250, 1);
    settle();
    chk("single_pre_valid", o_event_valid, 0);
    tick(90, 1);
    settle();
    chk("single_valid", o_event_valid, 1);
    chk("single_amp", o_event_amp, 300);
    chk("single_time", o_event_time, 13);
    chk("single_width", o_event_width, 3);
    chk("single_pileup", o_event_pileup, 0);
    repeat (8) tick(0, 1);

    // Backpressure: second event dropped while first is held.
    tick(200, 0); tick(220, 0); tick(0, 0);
    repeat (10) tick(0, 0);
    tick(150, 0); tick(0, 0);
    settle();
    chk("bp_lost", o_lost_count, 1);
    chk("bp_valid", o_event_valid, 1);
    chk("bp_amp", o_event_amp, 220);
    tick(0, 1);
    settle();
    chk("bp_drained", o_event_valid, 0);
    repeat (6) tick(0, 1);

    // Pile-up.
    tick(200, 0);
    t_first = last_tag;
    repeat (19) tick(200, 0);
    tick(0, 0);
    settle();
    chk("pu_width", o_event_width, 16);
    chk("pu_pileup", o_event_pileup, 1);
    chk("pu_amp", o_event_amp, 200);
    chk("pu_time", o_event_time, t_first);
    chk("pu_busy", o_busy, 1);
    tick(0, 1);
    repeat (8) tick(0, 1);

    // Threshold tie and equal peaks.
    tick(100, 1); tick(100, 1);
    settle();
    chk("tie_busy", o_busy, 0);
    tick(101, 1); tick(400, 1);
    t_peak = last_tag;
    tick(400, 1); tick(50, 1);
    settle();
    chk("tie_amp", o_event_amp, 400);
    chk("tie_time", o_event_time, t_peak);
    chk("tie_width", o_event_width, 3);
    repeat (6) tick(0, 1);

    // Hold-off: pulse at end+2 ignored, pulse at end+6 detected.
    tick(200, 1); tick(0, 1); tick(0, 1); tick(300, 1); tick(0, 1);
    tick(0, 1); tick(0, 1); tick(333, 1);
    settle();
    chk("ho_busy", o_busy, 1);
    tick(0, 1);
    settle();
    chk("ho_amp", o_event_amp, 333);
    chk("ho_width", o_event_width, 1);
    chk("ho_lost", o_lost_count, 1);
    repeat (6) tick(0, 1);

    // Completion coinciding with handshake.
    tick(250, 0); tick(0, 0);
    repeat (6) tick(0, 0);
    tick(260, 0); tick(0, 1);
    settle();
    chk("hand_valid", o_event_valid, 1);
    chk("hand_amp", o_event_amp, 260);
    chk("hand_lost", o_lost_count, 1);
    tick(0, 1);
    repeat (6) tick(0, 0);

    // Reset with an event pending and a pulse in flight.
    tick(500, 0); tick(0, 0);
    repeat (6) tick(0, 0);
    tick(300, 0); tick(310, 0);
    @(negedge clk);
    i_reset = 1'b1;
    settle();
    chk("mrst_valid", o_event_valid, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_lost", o_lost_count, 0);
    chk("mrst_amp", o_event_amp, 0);
    @(negedge clk);
    i_filter_data = '0;
    i_event_ready = 1'b1;
    i_reset = 1'b0;
    tick(0, 1); tick(0, 1); tick(120, 1); tick(0, 1);
    settle();
    chk("post_rst_amp", o_event_amp, 120);
    chk("post_rst_time", o_event_time, 3);

    // Random pulses, random backpressure, rare resets.
    burst = 0;
    for (int k = 0; k < 4000; k++) begin
      if (burst == 0 && $urandom_range(0, 5) == 0) burst = $urandom_range(1, 24);
      if (burst > 0) begin
        v = ($urandom_range(0, 7) == 0) ? 101 : int'($urandom_range(101, 800));
        burst--;
      end else begin
        v = int'($urandom_range(0, 200)) - 100;
      end
      if ($urandom_range(0, 999) == 0) begin
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
      end
      tick(v, $urandom_range(0, 3) != 0);
    end
    repeat (30) tick(0, 1);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/filter_peak_detector.md
# filter_peak_detector

Downstream of the trapezoidal shaping filter: consumes the filter's per-cycle signed output and detects pulses by threshold crossing. For each pulse it captures the peak amplitude, the timestamp of the peak, the width above threshold and a pile-up flag. Results are presented as single events on a valid/ready interface to the event readout logic. Events that cannot be delivered are counted as lost.

## Interface
- THRESHOLD, default 100: signed trigger level; a sample is "above" when strictly greater.
- HOLDOFF, default 8: dead-time cycles after each event end.
- MAX_WIDTH, default 64: width, in samples, at which a pulse is declared pile-up.
- TS_WIDTH, default 32: timestamp counter width.
- W_WIDTH, default 8: width-field size; must satisfy 2^W_WIDTH > MAX_WIDTH.
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-high reset.
- filter_data  in  SIZE_FILTER_DATA (signed)  filter output, one valid sample every clk.
- event_valid  out  1  event registers hold an undelivered event.
- event_ready  in  1  consumer accepts the event when high together with event_valid.
- event_amp  out  SIZE_FILTER_DATA (signed)  peak amplitude.
- event_time  out  TS_WIDTH  timestamp of the peak sample.
- event_width  out  W_WIDTH  number of consecutive samples above THRESHOLD.
- event_pileup  out  1  pulse reached MAX_WIDTH.
- lost_count  out  8  saturating count of dropped events.
- busy  out  1  FSM not in IDLE.

## Operation
- Free-running timestamp counter `ts`: 0 after reset, +1 every clk, wraps modulo 2^TS_WIDTH without flagging.
- FSM states:
  - IDLE: when filter_data > THRESHOLD, load max = sample, t_max = ts, width = 1, and go to TRACK.
  - TRACK:
    - Sample > THRESHOLD: width +1. If sample > max (strict; ties keep the earliest), update max and t_max.
    - Sample ≤ THRESHOLD: complete the event with pileup = 0 and go to DEAD.
    - Width reaching MAX_WIDTH while still above: complete the event with pileup = 1 and go to WAIT_LOW.
  - WAIT_LOW: ignore samples until one is ≤ THRESHOLD, then go to DEAD.
  - DEAD: count HOLDOFF cycles, ignoring input, then go to IDLE. HOLDOFF = 0 returns to IDLE on the next cycle.
- Event completion writes the output registers:
  - Allowed if event_valid = 0, or if event_valid = 1 and event_ready = 1 in the same cycle (handoff: the old event is delivered and the new one loaded).
  - Otherwise the new event is dropped and lost_count increments, saturating at 255. Output registers are untouched.
- event_valid clears on the handshake, unless a new event is loaded in the same cycle.
- Output fields stay stable while event_valid = 1 and event_ready = 0.
- Width arithmetic: event_width never exceeds MAX_WIDTH; no wrap.
- Reset (any time, including mid-pulse or with an event pending):
  - FSM → IDLE, ts = 0.
  - All outputs 0: event_valid, event_amp, event_time, event_width, event_pileup, lost_count, busy.
  - The pending event is discarded and not counted as lost.

## Timing
- Samples are taken at the rising edge of clk. The first above-threshold sample at edge N puts the FSM in TRACK after edge N, so busy = 1 in cycle N+1.
- Latency: the first sample ≤ THRESHOLD at edge E loads the event at edge E; event_valid = 1 from cycle E+1. For pile-up, the load happens at the edge where width reaches MAX_WIDTH.
- Handshake: transfer occurs on an edge where event_valid && event_ready. event_ready with event_valid = 0 has no effect.
- Re-trigger: the earliest next IDLE detection is HOLDOFF+1 edges after the DEAD entry edge.
- event_time equals the ts value at the edge that sampled the peak.

## Structure
- In package_settings: SIZE_FILTER_DATA (existing), plus a typedef for the FSM state enum (IDLE, TRACK, WAIT_LOW, DEAD) and an event struct {amp, time, width, pileup}.
- One sub-module, peak_event_buffer: the one-entry output register with the valid/ready handshake, the load-or-drop decision and the saturating lost_count. The FSM and timestamp counter stay in the top module.

## Test plan
All scenarios use THRESHOLD = 100, HOLDOFF = 4, MAX_WIDTH = 16, with event_ready tied high unless stated.
- Single pulse: samples 0, 50, 150, 300, 250, 90, 0 starting at ts = 10 (150 sampled at ts = 12).
  - Expect one event: amp = 300, time = 13, width = 3, pileup = 0.
  - event_valid rises the cycle after 90 is sampled.
- Backpressure:
  - Two pulses separated by 10 cycles, event_ready low. Expect the first event held stable, the second dropped, lost_count = 1.
  - Raise event_ready. Expect the first event delivered, then event_valid = 0.
- Pile-up: 20 consecutive samples of 200, then 0.
  - Expect an event with width = 16, pileup = 1, amp = 200, time = the first sample's ts.
  - busy stays high through WAIT_LOW and DEAD. No second event.
- Tie and threshold edge:
  - Samples 100, 100 produce no trigger.
  - Samples 101, 400, 400, 50 give amp = 400, time = first 400, width = 3.
- Hold-off and handoff:
  - A second pulse arriving 2 cycles after the first ends is ignored.
  - A pulse arriving 6 cycles after detects normally.
  - A completion coinciding with a handshake loads the new event with no loss.
- Reset mid-TRACK and with a pending event: all outputs 0 next cycle, ts = 0, lost_count = 0; a subsequent pulse detects normally.
